// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the ALU requesters and the ALU arbiter.
// Per-requester fields are packed side by side; slice i belongs to requester i.
interface alu_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_lock;
  logic [4*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_data;
  logic              rsp_carry;
  logic              rsp_z;

  modport master (
    output req_valid, req_lock, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_z
  );

  modport slave (
    input  req_valid, req_lock, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_z
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one execute-stage ALU among NREQ requesters,
// with an optional per-op lock that keeps the grant for chained sequences.
module alu_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic         alu_ex,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  input  logic [W-1:0] alu_res,
  input  logic         alu_carry,
  input  logic         alu_z,
  output logic         busy
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic            lock_q;
  logic [NREQ-1:0] rsp_valid_q;

  logic [GW-1:0]   winner_c;
  logic            any_valid_c;
  logic            found_c;
  int unsigned     idx_c;

  // Winner: lock owner if it still requests, else first valid index after last_grant.
  always_comb begin
    winner_c    = last_grant;
    any_valid_c = |bus.req_valid;
    found_c     = 1'b0;
    idx_c       = 0;
    if (lock_q && bus.req_valid[last_grant]) begin
      winner_c = last_grant;
    end else begin
      for (int unsigned i = 1; i <= NREQ; i++) begin
        idx_c = (32'(last_grant) + i) % NREQ;
        if (!found_c && bus.req_valid[GW'(idx_c)]) begin
          found_c  = 1'b1;
          winner_c = GW'(idx_c);
        end
      end
    end
  end

  assign bus.req_ready = (rst_n && state == IDLE && any_valid_c) ?
                         (NREQ'(1) << winner_c) : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = alu_res;
  assign bus.rsp_carry = alu_carry;
  assign bus.rsp_z     = alu_z;

  // Sequencer: accept -> one-cycle ALU issue -> hold response until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= GW'(NREQ - 1);
      lock_q      <= 1'b0;
      alu_ex      <= 1'b0;
      alu_op      <= '0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      rsp_valid_q <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid_c) begin
            alu_op     <= bus.req_op[32'(winner_c) * 32'd4 +: 4];
            alu_op1    <= bus.req_a[32'(winner_c) * W +: W];
            alu_op2    <= bus.req_b[32'(winner_c) * W +: W];
            last_grant <= winner_c;
            lock_q     <= bus.req_lock[winner_c];
            alu_ex     <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end else begin
            // Owner dropped its request: the lock lapses.
            lock_q <= 1'b0;
          end
        end
        ISSUE: begin
          alu_ex      <= 1'b0;
          rsp_valid_q <= NREQ'(1) << last_grant;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[last_grant]) begin
            rsp_valid_q <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          alu_ex      <= 1'b0;
          rsp_valid_q <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level model
// that tracks each accepted op through its issue and response phases.
module tb_alu_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned W    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  logic         alu_ex;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_op1, alu_op2;
  logic [W-1:0] alu_res;
  logic         alu_carry, alu_z;
  logic         busy;

  alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_ex(alu_ex), .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_z(alu_z), .busy(busy)
  );

  // Result as {carry, zero, result}; carry is a borrow for SUB.
  function automatic logic [W+1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    logic c;
    c = 1'b0;
    case (op)
      4'd1:    {c, r} = {1'b0, a} + {1'b0, b};
      4'd2:    begin r = a - b; c = (a < b); end
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      4'd5:    r = a ^ b;
      4'd10:   r = W'(a == b);
      default: r = ~a ^ b;
    endcase
    return {c, (r == '0), r};
  endfunction

  // Execute-stage ALU stand-in: registers a result when enabled.
  always @(posedge clk) begin
    if (alu_ex) {alu_carry, alu_z, alu_res} <= alu_fn(alu_op, alu_op1, alu_op2);
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Requester sources
  logic         src_valid [NREQ];
  logic         src_lock  [NREQ];
  logic [3:0]   src_op    [NREQ];
  logic [W-1:0] src_a     [NREQ];
  logic [W-1:0] src_b     [NREQ];
  logic [NREQ-1:0] rr;
  bit keep_valid = 1'b0;

  // Model: one outstanding op, its age in cycles since acceptance
  bit         m_busy;
  int         m_age, m_g, m_last;
  bit         m_lock;
  logic [3:0] m_op;
  logic [W-1:0] m_a, m_b;
  int cyc = 0;
  int acc_g[$];
  int acc_c[$];

  function automatic int pick(input logic [NREQ-1:0] v);
    if (m_lock && v[m_last]) return m_last;
    for (int k = 1; k <= int'(NREQ); k++)
      if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_g = 0; m_last = NREQ - 1; m_lock = 1'b0;
    m_op = '0; m_a = '0; m_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      src_valid[i] = 1'b0; src_lock[i] = 1'b0; src_op[i] = '0; src_a[i] = '0; src_b[i] = '0;
    end
  endtask

  task automatic cycle();
    logic [NREQ-1:0] v, one, exp_rdy, exp_rv;
    logic [W+1:0] r;
    int g;
    one = NREQ'(1);
    for (int i = 0; i < int'(NREQ); i++) begin
      v[i] = src_valid[i];
      bus.req_valid[i] = src_valid[i];
      bus.req_lock[i]  = src_lock[i];
      bus.req_op[4*i +: 4] = src_op[i];
      bus.req_a[W*i +: W]  = src_a[i];
      bus.req_b[W*i +: W]  = src_b[i];
    end
    bus.rsp_ready = rr;
    #1;
    g = pick(v);
    exp_rdy = (!m_busy && g >= 0) ? (one << g) : '0;
    exp_rv  = (m_busy && m_age >= 2) ? (one << m_g) : '0;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
    check("busy", 64'(busy), 64'(m_busy));
    check("alu_ex", 64'(alu_ex), 64'(m_busy && m_age == 1));
    check("alu_op", 64'(alu_op), 64'(m_op));
    check("alu_op1", 64'(alu_op1), 64'(m_a));
    check("alu_op2", 64'(alu_op2), 64'(m_b));
    if (m_busy && m_age >= 2) begin
      r = alu_fn(m_op, m_a, m_b);
      check("rsp_data", 64'(bus.rsp_data), 64'(r[W-1:0]));
      check("rsp_z", 64'(bus.rsp_z), 64'(r[W]));
      check("rsp_carry", 64'(bus.rsp_carry), 64'(r[W+1]));
    end
    @(posedge clk);
    if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1'b1; m_age = 1; m_g = g; m_last = g; m_lock = src_lock[g];
        m_op = src_op[g]; m_a = src_a[g]; m_b = src_b[g];
        acc_g.push_back(g); acc_c.push_back(cyc);
        if (!keep_valid) src_valid[g] = 1'b0;
      end else begin
        m_lock = 1'b0;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rr[m_g]) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    rr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_g.delete(); acc_c.delete();
  endtask

  task automatic set_src(input int i, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic lk);
    src_valid[i] = 1'b1; src_op[i] = op; src_a[i] = a; src_b[i] = b; src_lock[i] = lk;
  endtask

  initial begin
    model_reset();
    rr = '0;
    for (int i = 0; i < int'(NREQ); i++) bus.req_valid[i] = 1'b0;
    bus.req_lock = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_alu_ex", 64'(alu_ex), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_alu_op1", 64'(alu_op1), 64'(0));
    do_reset();

    // Single ADD with carry-out and zero result
    rr = '1;
    set_src(0, 4'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    cycle(); cycle();
    check("add_data", 64'(bus.rsp_data), 64'(0));
    check("add_carry", 64'(bus.rsp_carry), 64'(1));
    check("add_z", 64'(bus.rsp_z), 64'(1));
    cycle();

    // SUB with borrow
    set_src(2, 4'd2, 32'd3, 32'd5, 1'b0);
    cycle(); cycle(); cycle();
    check("sub_data", 64'(bus.rsp_data), 64'(32'hFFFF_FFFE));
    check("sub_carry", 64'(bus.rsp_carry), 64'(1));
    check("sub_z", 64'(bus.rsp_z), 64'(0));
    cycle();

    // Round-robin with two requesters continuously valid
    do_reset();
    rr = '1; keep_valid = 1'b1;
    set_src(0, 4'd4, 32'h11, 32'h22, 1'b0);
    set_src(1, 4'd5, 32'h33, 32'h44, 1'b0);
    repeat (12) cycle();
    check("rr_count", 64'(acc_g.size()), 64'(4));
    for (int k = 0; k < acc_g.size(); k++) begin
      check("rr_grant", 64'(acc_g[k]), 64'(k % 2));
      if (k > 0) check("rr_gap", 64'(acc_c[k] - acc_c[k-1]), 64'(3));
    end

    // Lock keeps requester 0 once, then released
    do_reset();
    rr = '1; keep_valid = 1'b1;
    set_src(0, 4'd1, 32'hFFFF_FFF0, 32'h20, 1'b1);
    set_src(1, 4'd3, 32'hF0F0, 32'hFF00, 1'b0);
    repeat (3) cycle();
    src_lock[0] = 1'b0; src_op[0] = 4'd1; src_a[0] = 32'd7; src_b[0] = 32'd8;
    repeat (6) cycle();
    check("lock_count", 64'(acc_g.size()), 64'(3));
    if (acc_g.size() == 3) begin
      check("lock_g0", 64'(acc_g[0]), 64'(0));
      check("lock_g1", 64'(acc_g[1]), 64'(0));
      check("lock_g2", 64'(acc_g[2]), 64'(1));
    end
    keep_valid = 1'b0;

    // Response back-pressure on SEQ
    do_reset();
    rr = '0;
    set_src(0, 4'd10, 32'd5, 32'd5, 1'b0);
    cycle(); cycle();
    set_src(1, 4'd4, 32'd1, 32'd2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("bp_data", 64'(bus.rsp_data), 64'(1));
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      cycle();
    end
    rr = '1;
    repeat (5) cycle();

    // Reset while the ALU is being enabled
    do_reset();
    rr = '1;
    set_src(0, 4'd1, 32'd1, 32'd2, 1'b0);
    set_src(1, 4'd2, 32'd9, 32'd4, 1'b0);
    cycle();
    check("iss_alu_ex", 64'(alu_ex), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_alu_ex", 64'(alu_ex), 64'(0));
    check("mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("mid_req_ready", 64'(bus.req_ready), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_alu_op", 64'(alu_op), 64'(0));
    check("mid_alu_op1", 64'(alu_op1), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_g.delete(); acc_c.delete();
    set_src(0, 4'd3, 32'hABCD, 32'h0FF0, 1'b0);
    set_src(1, 4'd2, 32'd9, 32'd4, 1'b0);
    repeat (8) cycle();
    check("post_rst_first", 64'(acc_g.size() > 0 ? acc_g[0] : -1), 64'(0));

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!src_valid[i] && $urandom_range(0, 2) == 0) begin
          src_valid[i] = 1'b1;
          src_op[i]    = 4'($urandom_range(0, 15));
          src_a[i]     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
          src_b[i]     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
          src_lock[i]  = ($urandom_range(0, 3) == 0);
        end
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
